// File: rtl/req_encoder_pkg.sv
// req_encoder_pkg: shared types and helpers for the request encoder.
//   state_t  - encoder FSM states (IDLE: nothing presented, HOLD: index presented)
//   onehot() - index to one-hot mask (same mapping as the 2x4 decoder, widened)
//   pe()     - priority function, returns the lowest set bit index (bit 0 wins)
// Helpers work on MAX_N-wide vectors; callers zero-extend / truncate to N.
package req_encoder_pkg;

    localparam int unsigned MAX_N     = 64;
    localparam int unsigned MAX_IDX_W = 6;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    function automatic logic [MAX_N-1:0] onehot(input logic [MAX_IDX_W-1:0] idx);
        logic [MAX_N-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // pe(0) returns 0, but callers never load the result when the input is zero.
    function automatic int unsigned pe(input logic [MAX_N-1:0] v);
        int unsigned r;
        r = 0;
        // Scan from the top so the lowest set bit is the last one written.
        for (int unsigned i = MAX_N; i > 0; i--) begin
            if (v[i-1]) r = i - 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/req_encoder_prio_enc.sv
// prio_enc: combinational N-to-IDX_W priority encoder.
//   vec   - input request vector
//   idx   - index of the lowest set bit of vec (don't care when vec == 0)
//   any_o - high when any bit of vec is set
module prio_enc
    import req_encoder_pkg::*;
#(
    parameter  int unsigned N     = 4,
    localparam int unsigned IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     vec,
    output logic [IDX_W-1:0] idx,
    output logic             any_o
);

    always_comb begin
        idx   = IDX_W'(pe(MAX_N'(vec)));
        any_o = |vec;
    end

endmodule

// File: rtl/req_encoder.sv
// req_encoder: sequential N-to-log2(N) priority encoder with request capture.
//   clk, rst  - clock; asynchronous active-high reset
//   req_i     - request pulses/levels, OR'd into the pending register each cycle
//   out_valid - out_idx holds a serviceable index
//   out_ready - consumer accepts out_idx when out_valid && out_ready
//   out_idx   - registered index of presented request (bit 0 highest priority)
//   pending_o - current pending register
//   overflow  - one-cycle registered pulse when a request hits a pending bit
module req_encoder
    import req_encoder_pkg::*;
#(
    parameter  int unsigned N     = 4,
    localparam int unsigned IDX_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req_i,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic [N-1:0]     pending_o,
    output logic             overflow
);

    state_t           state;
    logic [N-1:0]     pending;
    logic [N-1:0]     clr;
    logic [N-1:0]     rem;
    logic [IDX_W-1:0] pend_idx;
    logic [IDX_W-1:0] rem_idx;
    logic             pend_any;
    logic             rem_any;

    // The presented bit is cleared on handshake; rem excludes this cycle's req_i.
    always_comb begin
        clr = '0;
        if (out_valid && out_ready) begin
            clr = N'(onehot(MAX_IDX_W'(out_idx)));
        end
        rem = pending & ~clr;
    end

    prio_enc #(.N(N)) u_pend_enc (
        .vec   (pending),
        .idx   (pend_idx),
        .any_o (pend_any)
    );

    prio_enc #(.N(N)) u_rem_enc (
        .vec   (rem),
        .idx   (rem_idx),
        .any_o (rem_any)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            pending   <= '0;
            out_valid <= 1'b0;
            out_idx   <= '0;
            overflow  <= 1'b0;
        end else begin
            // A request landing on a bit being cleared wins and is not an overflow.
            pending  <= rem | req_i;
            overflow <= |(req_i & rem);
            case (state)
                IDLE: begin
                    if (pend_any) begin
                        out_idx   <= pend_idx;
                        out_valid <= 1'b1;
                        state     <= HOLD;
                    end
                end
                HOLD: begin
                    // No preemption: index only changes on a handshake.
                    if (out_valid && out_ready) begin
                        if (rem_any) begin
                            out_idx <= rem_idx;
                        end else begin
                            out_valid <= 1'b0;
                            state     <= IDLE;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign pending_o = pending;

endmodule

// File: doc/req_encoder.md
Name: req_encoder

Overview:
Sequential N-to-log2(N) priority encoder with request capture and a valid/ready output. It is the encode-side counterpart of the team's 2x4 one-hot decoder. Single-cycle request pulses on N one-hot-style lines are latched into a pending register. The block then emits the binary index of the highest-priority pending line, one index per handshake, and clears each serviced bit. Default configuration is 4 lines to a 2-bit index, which pairs directly with the 2x4 decoder.

Parameters:
N, 4, number of request lines; must be >= 2.
IDX_W, $clog2(N), index width; localparam derived from N, not overridable.

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  reset, asynchronous, active-high
req_i  input  N  request pulses/levels; bit k is sampled every cycle and OR'd into pending[k]
out_valid  output  1  out_idx holds a serviceable index
out_ready  input  1  consumer accepts out_idx when out_valid && out_ready (handshake)
out_idx  output  IDX_W  binary index of presented request; bit 0 is the highest priority
pending_o  output  N  current pending register, for status/debug
overflow  output  1  one-cycle registered pulse when a request hits an already-pending bit

Behaviour:
- Reset (async, immediate, no clock required): pending=0, out_valid=0, out_idx=0, overflow=0, FSM=IDLE. Reset mid-handshake drops all pending and presented requests.
- Handshake and clear mask:
  - hs = out_valid && out_ready.
  - clr = onehot(out_idx) when hs, else 0.
- Pending update: pending <= (pending & ~clr) | req_i.
  - If req_i[k] is set in the same cycle bit k is cleared, the request wins. The bit stays set and is presented again later.
- Overflow: overflow <= |(req_i & pending & ~clr). Duplicates merge; there is no counting.
- Priority function pe(v): lowest set bit index; pe(0) is undefined and never loaded.
- FSM states:
  - IDLE (out_valid=0): if pending != 0, then out_idx <= pe(pending), out_valid <= 1, go to HOLD. Otherwise stay in IDLE.
  - HOLD (out_valid=1):
    - No hs: out_idx and out_valid hold stable. A newly arrived higher-priority request does not preempt the presented index.
    - hs: let rem = pending & ~clr. If rem != 0, out_idx <= pe(rem) and stay in HOLD (back-to-back, one index per cycle). If rem == 0, out_valid <= 0 and go to IDLE.
- Latency:
  - req_i at cycle t sets pending at edge t+1.
  - out_valid is visible at t+2 when starting from IDLE.
  - req_i asserted in a handshake cycle is not included in that cycle's rem. It is picked up from pending afterwards, which adds one extra cycle.
- out_idx is always a registered output; there is no combinational path from req_i or out_ready to any output.
- out_ready is ignored while out_valid=0.

Decomposition:
- Shared package: onehot(idx) function (same mapping as the 2x4 decoder, generalised to N), pe() priority function, FSM state enum {IDLE, HOLD}.
- Sub-module prio_enc: combinational, N-bit in to IDX_W-bit idx plus any_o. Instantiated twice: once on pending, once on rem.
- Top-level req_encoder contains: pending register, FSM, overflow flop.

Test Plan:
1. Assert rst mid-run with out_valid=1 and pending=4'b1010, no clock edge -> out_valid, out_idx, pending_o and overflow all read 0 immediately. After deassert, the block idles with out_valid=0.
2. req_i=4'b0100 for one cycle at t, out_ready=1 -> pending_o=0100 at t+1. out_valid=1 and out_idx=2 at t+2. out_valid=0 and pending_o=0000 at t+3.
3. req_i=4'b1011 for one cycle, out_ready held 1 -> out_idx sequence 0,1,3 on consecutive cycles with out_valid held high, then out_valid=0. Exactly 3 handshakes.
4. pending=0100, out_ready=0: out_idx=2 held. Then inject req_i=0001 -> out_idx stays 2 for 5 cycles, pending_o=0101. Raise out_ready -> next cycle out_idx=0, then out_valid drops.
5. Overflow:
   - pending_o=0010 and req_i=0010 -> overflow=1 for exactly one cycle, and only a single handshake with idx 1 occurs.
   - req_i=0010 in the same cycle as the handshake on idx 1 -> overflow stays 0 and idx 1 is presented again.
6. N=8 build: req_i=8'b1000_0000 -> out_idx=3'd7. Then req_i=8'b1111_1111 -> indices 0..7 in order, no overflow.
